inv_sub_bytes_sched: RTL and testbench

INV_SUB_BYTES_SCHED -- requirements
Module: inv_sub_bytes_sched

---
 rtl/inv_sub_bytes_sched.sv | 94 +++++++++
 tb/tb_inv_sub_bytes_sched.sv | 159 +++++++++++++++
 2 files changed

// File: rtl/inv_sub_bytes_sched.sv
// inv_sub_bytes_sched: iterative AES InvSubBytes over a 128-bit state with valid/ready handshakes.
// Ports: clk, reset (sync, active-high); in_valid/in_ready/in_state accept a state;
// out_valid/out_ready/out_state present the result; busy is high outside IDLE.
// Parameter LSB_FIRST: 1 walks byte 0 first, 0 walks byte 15 first (same result).
// Macro INV_SUB_BYTES_SCHED_WORD_EN: four InvSBox lanes, one 32-bit word per cycle.
module inv_sub_bytes_sched #(
  parameter int LSB_FIRST = 1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_state,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_state,
  output logic         busy
);
`ifdef INV_SUB_BYTES_SCHED_WORD_EN
  localparam int LANES = 4;
`else
  localparam int LANES = 1;
`endif
  localparam logic [3:0] STEP = 4'(LANES);
  localparam logic [3:0] LAST = 4'(16 - LANES);
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] BUSY = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  function automatic logic [7:0] gmul(input logic [7:0] p, input logic [7:0] q);
    logic [7:0] r, s;
    r = '0;
    s = p;
    for (int i = 0; i < 8; i++) begin
      r = q[i] ? r ^ s : r;
      s = {s[6:0], 1'b0} ^ (s[7] ? 8'h1b : 8'h00);
    end
    return r;
  endfunction

  // Undo the affine transform, then invert in GF(2^8) as x^254 (maps 0 to 0).
  function automatic logic [7:0] inv_sbox(input logic [7:0] a);
    logic [7:0] x, acc;
    x = {a[1]^a[4]^a[6], a[0]^a[3]^a[5], a[7]^a[2]^a[4], a[6]^a[1]^a[3],
         a[5]^a[0]^a[2], a[4]^a[7]^a[1], a[3]^a[6]^a[0], a[2]^a[5]^a[7]} ^ 8'h05;
    acc = 8'h01;
    for (int i = 1; i < 8; i++) begin
      x = gmul(x, x);
      acc = gmul(acc, x);
    end
    return acc;
  endfunction

  logic [1:0]   state;
  logic [3:0]   cnt;
  logic [127:0] work, nxt;
  logic [3:0]   idx  [LANES];
  logic [7:0]   lane [LANES];
  logic         accept;

  for (genvar j = 0; j < LANES; j++) begin : g_lane
    assign idx[j]  = (LSB_FIRST != 0) ? cnt + 4'(j) : 4'd15 - cnt - 4'(j);
    assign lane[j] = inv_sbox(work[{idx[j], 3'b000} +: 8]);
  end

  always_comb begin
    nxt = work;
    for (int j = 0; j < LANES; j++) nxt[{idx[j], 3'b000} +: 8] = lane[j];
  end

  assign in_ready  = (state == IDLE) || (state == DONE && out_ready);
  assign accept    = in_valid && in_ready;
  assign out_valid = state == DONE;
  assign busy      = state != IDLE;
  assign out_state = work;

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= '0;
      work  <= '0;
    end else if (accept) begin
      state <= BUSY;
      cnt   <= '0;
      work  <= in_state;
    end else if (state == BUSY) begin
      work  <= nxt;
      cnt   <= cnt + STEP;
      state <= (cnt == LAST) ? DONE : BUSY;
    end else if (state == DONE && out_ready) begin
      state <= IDLE;
    end
  end
endmodule

// File: tb/tb_inv_sub_bytes_sched.sv
// tb_inv_sub_bytes_sched: directed checks of inv_sub_bytes_sched in both byte orders.
module tb_inv_sub_bytes_sched;
`ifdef INV_SUB_BYTES_SCHED_WORD_EN
  localparam int LAT = 4;
`else
  localparam int LAT = 16;
`endif
  localparam int TMO = 60;
  localparam logic [127:0] ALL63 = {16{8'h63}};
  localparam logic [127:0] PAT   = {{12{8'h63}}, 8'hed, 8'h16, 8'h7c, 8'h00};
  localparam logic [127:0] PAT_R = {96'h0, 8'h53, 8'hff, 8'h01, 8'h52};
  localparam logic [127:0] HI    = {8'h00, 8'h7c, 8'h16, 8'hed, {12{8'h63}}};
  localparam logic [127:0] HI_R  = {8'h52, 8'h01, 8'hff, 8'h53, 96'h0};

  logic clk = 0, reset = 1, in_valid = 0, out_ready = 1;
  logic [127:0] in_state = '0;
  logic in_ready_a, out_valid_a, busy_a, in_ready_b, out_valid_b, busy_b;
  logic [127:0] out_a, out_b, snap;
  int n_cmp = 0, n_bad = 0, n, pulses;

  always #5 clk = ~clk;

  inv_sub_bytes_sched #(.LSB_FIRST(1)) dut_a (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready_a),
    .in_state(in_state), .out_valid(out_valid_a), .out_ready(out_ready),
    .out_state(out_a), .busy(busy_a));

  inv_sub_bytes_sched #(.LSB_FIRST(0)) dut_b (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready_b),
    .in_state(in_state), .out_valid(out_valid_b), .out_ready(out_ready),
    .out_state(out_b), .busy(busy_b));

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic start(input logic [127:0] s);
    in_valid = 1;
    in_state = s;
    @(posedge clk);
    #1 in_valid = 0;
  endtask

  task automatic wait_out(output int cycles);
    cycles = 0;
    while (cycles < TMO) begin
      @(posedge clk);
      #1 cycles++;
      if (out_valid_a) break;
    end
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check("rst_out_valid", 128'(out_valid_a), 128'(0));
    check("rst_busy", 128'(busy_a), 128'(0));
    check("rst_in_ready", 128'(in_ready_a), 128'(1));
    check("rst_work", out_a, '0);
    check("rst_work_b", out_b, '0);
    reset = 0;
    @(posedge clk);
    #1;

    start(ALL63);
    wait_out(n);
    check("all63_lat", 128'(n), 128'(LAT));
    check("all63_out_a", out_a, '0);
    check("all63_out_b", out_b, '0);
    check("all63_valid_b", 128'(out_valid_b), 128'(1));
    @(posedge clk);
    #1 check("all63_idle", 128'(out_valid_a), 128'(0));

    start(PAT);
    wait_out(n);
    check("pat_lat", 128'(n), 128'(LAT));
    check("pat_out_a", out_a, PAT_R);
    check("pat_out_b", out_b, PAT_R);
    @(posedge clk);
    #1;

    out_ready = 0;
    start(HI);
    wait_out(n);
    check("stall_lat", 128'(n), 128'(LAT));
    check("stall_first", out_a, HI_R);
    snap = out_a;
    for (int i = 0; i < 10; i++) begin
      in_valid = i[0] == 1'b0;
      in_state = ALL63 ^ 128'(i);
      @(posedge clk);
      #1;
      check("stall_hold", out_a, snap);
      check("stall_in_ready", 128'(in_ready_a), 128'(0));
      check("stall_valid", 128'(out_valid_a), 128'(1));
    end
    in_valid = 0;
    out_ready = 1;
    @(posedge clk);
    #1;
    check("release_valid", 128'(out_valid_a), 128'(0));
    check("release_busy", 128'(busy_a), 128'(0));

    out_ready = 0;
    start(ALL63);
    wait_out(n);
    check("b2b_first", out_a, '0);
    in_valid = 1;
    in_state = PAT;
    out_ready = 1;
    @(posedge clk);
    #1 in_valid = 0;
    check("b2b_busy", 128'(busy_a), 128'(1));
    check("b2b_gap_valid", 128'(out_valid_a), 128'(0));
    wait_out(n);
    check("b2b_period", 128'(n + 1), 128'(LAT + 1));
    check("b2b_out_a", out_a, PAT_R);
    check("b2b_out_b", out_b, PAT_R);
    @(posedge clk);
    #1;

    start(PAT);
    repeat (LAT / 2 - 1) @(posedge clk);
    #1 reset = 1;
    @(posedge clk);
    #1 reset = 0;
    check("midrst_busy", 128'(busy_a), 128'(0));
    check("midrst_valid", 128'(out_valid_a), 128'(0));
    check("midrst_in_ready", 128'(in_ready_a), 128'(1));
    check("midrst_work", out_a, '0);
    wait_out(n);
    check("midrst_no_out", 128'(n), 128'(TMO));

    start(HI);
    pulses = 0;
    snap = '0;
    for (int i = 0; i < 40; i++) begin
      in_valid = i < LAT - 2;
      in_state = PAT;
      @(posedge clk);
      #1;
      if (out_valid_a) begin
        pulses++;
        snap = out_a;
        check("ign_out_b", out_b, HI_R);
      end
    end
    in_valid = 0;
    check("ign_pulses", 128'(pulses), 128'(1));
    check("ign_out_a", snap, HI_R);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
